pc_next_unit: RTL and testbench

Sequential program-counter stage sitting directly downstream of the 32-bit shift-left-two stage.
- Consumes the word-aligned branch offset (sign-extended immediate << 2) and adds it to PC+4 to form the branch target.
- Selects the next PC among sequential, branch, jump and jump-register targets, and holds the PC register.
- Generates a one-cycle flush to the fetch/decode path on every redirect.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pc_target_mux.sv | 53 +++++
 rtl/pc_next_unit.sv | 113 +++++++++++
 tb/tb_pc_next_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the program-counter stage.
//   pc_state_t    : PC sequencing states.
//   next_pc_sel_t : which target source feeds the next PC.
//   PC_INC        : sequential instruction stride.
//   RESET_PC_DEFAULT : default PC after reset.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL,
    REDIRECT
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } next_pc_sel_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target generation and priority select.
// Ports:
//   pc_i          : current PC
//   branch_i, bne_i, zero_i : conditional branch decode and ALU zero flag
//   offset_sl2_i  : sign-extended immediate already shifted left by two
//   jump_i, jump_index_i    : j/jal decode and instr[25:0]
//   jr_i, jr_target_i       : jr decode and rs value
//   pc_plus4_o    : pc_i + 4
//   next_pc_o     : selected target (jr > jump > taken branch > sequential)
//   sel_o         : which source was selected
module pc_target_mux
  import cpu_pkg::*;
(
  input  logic [31:0]  pc_i,
  input  logic         branch_i,
  input  logic         bne_i,
  input  logic         zero_i,
  input  logic [31:0]  offset_sl2_i,
  input  logic         jump_i,
  input  logic [25:0]  jump_index_i,
  input  logic         jr_i,
  input  logic [31:0]  jr_target_i,
  output logic [31:0]  pc_plus4_o,
  output logic [31:0]  next_pc_o,
  output next_pc_sel_t sel_o
);

  logic        taken;
  logic [31:0] br_target;
  logic [31:0] j_target;

  // Additions wrap modulo 2^32 by width truncation.
  assign pc_plus4_o = pc_i + PC_INC;
  assign br_target  = pc_plus4_o + offset_sl2_i;
  assign j_target   = {pc_plus4_o[31:28], jump_index_i, 2'b00};
  assign taken      = branch_i & (zero_i ^ bne_i);

  always_comb begin
    sel_o     = SEL_SEQ;
    next_pc_o = pc_plus4_o;
    if (jr_i) begin
      sel_o     = SEL_JR;
      next_pc_o = jr_target_i;
    end else if (jump_i) begin
      sel_o     = SEL_J;
      next_pc_o = j_target;
    end else if (taken) begin
      sel_o     = SEL_BR;
      next_pc_o = br_target;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the PC, selects the next PC and flags redirects.
// Optional feature macro: BRANCH_STATS_EN adds taken_cnt_o / redirect_cnt_o.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   stall_i            : hold PC and state
//   branch_i, bne_i, zero_i, offset_sl2_i : conditional branch inputs
//   jump_i, jump_index_i                  : j/jal inputs
//   jr_i, jr_target_i                     : jr inputs
//   pc_o, pc_plus4_o   : current PC and PC + 4
//   pc_valid_o         : pc_o is fetchable (all states except BOOT)
//   flush_o            : one-cycle bubble on the first cycle after a redirect
//   taken_cnt_o, redirect_cnt_o : saturating statistics (BRANCH_STATS_EN only)
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              bne_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] offset_sl2_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
`ifdef BRANCH_STATS_EN
  output logic [31:0]       taken_cnt_o,
  output logic [31:0]       redirect_cnt_o,
`endif
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              pc_valid_o,
  output logic              flush_o
);

  pc_state_t    state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  next_pc;
  next_pc_sel_t sel;
  logic         advance;

  pc_target_mux u_pc_target_mux (
    .pc_i         (pc_q),
    .branch_i     (branch_i),
    .bne_i        (bne_i),
    .zero_i       (zero_i),
    .offset_sl2_i (offset_sl2_i),
    .jump_i       (jump_i),
    .jump_index_i (jump_index_i),
    .jr_i         (jr_i),
    .jr_target_i  (jr_target_i),
    .pc_plus4_o   (pc_plus4_o),
    .next_pc_o    (next_pc),
    .sel_o        (sel)
  );

  // RUN, STALL-release and REDIRECT all evaluate the decode inputs identically.
  assign advance = (state_q != BOOT) && !stall_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (stall_i) begin
      state_d = STALL;
    end else begin
      pc_d    = next_pc;
      state_d = (sel == SEL_SEQ) ? RUN : REDIRECT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q != BOOT);
  // A stall in REDIRECT moves to STALL, so the pulse never exceeds one cycle.
  assign flush_o    = (state_q == REDIRECT);

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else if (advance) begin
      if (sel == SEL_BR && taken_cnt_q != 32'hFFFF_FFFF) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
      if (sel != SEL_SEQ && redirect_cnt_q != 32'hFFFF_FFFF) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign taken_cnt_o    = taken_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        bne_i = 1'b0;
  logic        zero_i = 1'b0;
  logic [31:0] offset_sl2_i = '0;
  logic        jump_i = 1'b0;
  logic [25:0] jump_index_i = '0;
  logic        jr_i = 1'b0;
  logic [31:0] jr_target_i = '0;
  logic [31:0] pc_o, pc_plus4_o;
  logic        pc_valid_o, flush_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_o, redirect_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        valid;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .bne_i        (bne_i),
    .zero_i       (zero_i),
    .offset_sl2_i (offset_sl2_i),
    .jump_i       (jump_i),
    .jump_index_i (jump_index_i),
    .jr_i         (jr_i),
    .jr_target_i  (jr_target_i),
`ifdef BRANCH_STATS_EN
    .taken_cnt_o    (taken_cnt_o),
    .redirect_cnt_o (redirect_cnt_o),
`endif
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .pc_valid_o   (pc_valid_o),
    .flush_o      (flush_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_dec();
    branch_i = 0; bne_i = 0; zero_i = 0; offset_sl2_i = '0;
    jump_i = 0; jump_index_i = '0; jr_i = 0; jr_target_i = '0;
  endtask

  // Push the expected post-edge outputs, clock once, pop and compare.
  task automatic cycle(input string tag, input logic [31:0] pc, input logic fl, input logic vl);
    exp_t e;
    sb.push_back('{pc: pc, flush: fl, valid: vl});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({tag, ".pc"}, pc_o, e.pc);
    check_eq({tag, ".pc4"}, pc_plus4_o, e.pc + 32'd4);
    check_eq({tag, ".flush"}, {31'b0, flush_o}, {31'b0, e.flush});
    check_eq({tag, ".valid"}, {31'b0, pc_valid_o}, {31'b0, e.valid});
  endtask

  task automatic go_jr(input logic [31:0] tgt);
    clear_dec(); jr_i = 1; jr_target_i = tgt;
    cycle("jr_setup", tgt, 1, 1);
    clear_dec();
  endtask

  task automatic branch(input logic z, input logic n, input logic [31:0] off);
    clear_dec(); branch_i = 1; zero_i = z; bne_i = n; offset_sl2_i = off;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_dec();
    rst_i = 1;
    cycle("reset", 32'h0, 0, 0);
    rst_i = 0;
    cycle("boot", 32'h0, 0, 1);
    cycle("seq4", 32'h4, 0, 1);
    cycle("seq8", 32'h8, 0, 1);
    cycle("seq12", 32'hC, 0, 1);

    // beq taken, back-to-back with the preceding jr redirect
    go_jr(32'h40);
    branch(1, 0, 32'h10);
    cycle("beq_taken", 32'h54, 1, 1);
    go_jr(32'h40);
    branch(0, 0, 32'h10);
    cycle("beq_not", 32'h44, 0, 1);
    branch(0, 1, 32'h10);
    cycle("bne_taken", 32'h58, 1, 1);
    branch(1, 1, 32'h10);
    cycle("bne_not", 32'h5C, 0, 1);

    go_jr(32'h40);
    branch(1, 0, 32'hFFFF_FFF8);
    cycle("neg_off", 32'h3C, 1, 1);
    go_jr(32'hFFFF_FFFC);
    cycle("wrap", 32'h0, 0, 1);
    go_jr(32'hFFFF_FFF8);
    branch(1, 0, 32'h8);
    cycle("br_wrap", 32'h4, 1, 1);

    go_jr(32'h1000_0000);
    branch(1, 0, 32'h10);
    jr_i = 1; jr_target_i = 32'h2000; jump_i = 1; jump_index_i = 26'h100;
    cycle("jr_prio", 32'h2000, 1, 1);
    clear_dec(); jump_i = 1; jump_index_i = 26'h100; branch_i = 1; zero_i = 1;
    cycle("jump", 32'h400, 1, 1);
    go_jr(32'hF000_0000);
    jump_i = 1; jump_index_i = 26'h3FF_FFFF;
    cycle("jump_hi", 32'hFFFF_FFFC, 1, 1);
    clear_dec();
    cycle("after_j", 32'h0, 0, 1);

    // stall coincident with a taken branch; branch resolves on release
    branch(1, 0, 32'h20);
    stall_i = 1;
    for (int i = 0; i < 3; i++) cycle("stall_hold", 32'h0, 0, 1);
    stall_i = 0;
    cycle("stall_rel", 32'h24, 1, 1);
    clear_dec(); stall_i = 1;
    cycle("redir_stall", 32'h24, 0, 1);
    stall_i = 0;
    cycle("redir_stall_rel", 32'h28, 0, 1);

    // reset during REDIRECT; inputs ignored in BOOT
    go_jr(32'h80);
    rst_i = 1;
    cycle("rst_redir", 32'h0, 0, 0);
    rst_i = 0; jr_i = 1; jr_target_i = 32'h500;
    cycle("boot_ignore", 32'h0, 0, 1);
    clear_dec();
    cycle("post_boot", 32'h4, 0, 1);
    stall_i = 1;
    cycle("stall_pre_rst", 32'h4, 0, 1);
    rst_i = 1;
    cycle("rst_stall", 32'h0, 0, 0);
    rst_i = 0; stall_i = 0;
    cycle("boot2", 32'h0, 0, 1);

`ifdef BRANCH_STATS_EN
    check_eq("cnt_clear_t", taken_cnt_o, 32'd0);
    check_eq("cnt_clear_r", redirect_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) begin
      branch(1, 0, 32'h0);
      stall_i = 1;
      cycle("cnt_stall", pc_o, 0, 1);
      stall_i = 0;
      cycle("cnt_tk", pc_o + 32'd4, 1, 1);
    end
    for (int i = 0; i < 2; i++) begin
      branch(0, 0, 32'h40);
      cycle("cnt_nt", pc_o + 32'd4, 0, 1);
    end
    clear_dec(); jump_i = 1; jump_index_i = 26'h10;
    cycle("cnt_j", 32'h40, 1, 1);
    clear_dec();
    check_eq("taken_cnt", taken_cnt_o, 32'd5);
    check_eq("redirect_cnt", redirect_cnt_o, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
